// File: rtl/seq_mag_comp_pkg.sv
// comp_pkg: shared FSM state type, sizing helpers and parameter legality check for seq_mag_comp.
package comp_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic bit legal(input int width, input int digit);
    return width >= 1 && digit >= 1 && width % digit == 0;
  endfunction
endpackage

// File: rtl/seq_mag_comp_digit_comp.sv
// digit_comp: combinational DIGIT-bit unsigned magnitude compare.
module digit_comp #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             lt,
  output logic             eq
);
  assign gt = x > y;
  assign lt = x < y;
  assign eq = x == y;
endmodule

// File: rtl/seq_mag_comp.sv
// seq_mag_comp: MSB-first multi-cycle magnitude comparator, DIGIT bits per cycle, early exit.
// Optional two's-complement mode via the COMP_SIGNED_EN macro (adds the sgn port).
module seq_mag_comp
  import comp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMP_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic             yg,
  output logic             yl,
  output logic             ye
);
  localparam int NDIG  = ndig(WIDTH, DIGIT);
  localparam int CNT_W = cnt_w(NDIG);
  if (!legal(WIDTH, DIGIT)) begin : g_bad_params
    $error("seq_mag_comp: WIDTH must be a positive multiple of DIGIT");
  end
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb, sa, sb, flip;
  logic [CNT_W-1:0] cnt;
  logic accept, last, gt, lt, eq;
`ifdef COMP_SIGNED_EN
  // flipping both MSBs maps two's-complement order onto unsigned order
  assign flip = sgn ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
`else
  assign flip = '0;
`endif
  assign accept = start && state != SCAN;
  assign last   = cnt == CNT_W'(NDIG - 1);
  assign sa     = ra << (int'(cnt) * DIGIT);
  assign sb     = rb << (int'(cnt) * DIGIT);
  digit_comp #(.DIGIT(DIGIT)) u_digit (
    .x (sa[WIDTH-1 -: DIGIT]),
    .y (sb[WIDTH-1 -: DIGIT]),
    .gt(gt),
    .lt(lt),
    .eq(eq)
  );
  always_comb begin
    state_nx = state;
    if (accept) state_nx = SCAN;
    else if (state == DONE) state_nx = IDLE;
    else if (state == SCAN && (!eq || last)) state_nx = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      yg    <= 1'b0;
      yl    <= 1'b0;
      ye    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ra  <= a ^ flip;
        rb  <= b ^ flip;
        cnt <= '0;
      end else if (state == SCAN && eq && !last) cnt <= cnt + 1'b1;
      if (state == SCAN && (!eq || last)) begin
        yg <= gt;
        yl <= lt;
        ye <= eq;
      end
    end
  end
  assign busy = state == SCAN;
  assign done = state == DONE;
endmodule

// File: tb/tb_seq_mag_comp.sv
// tb_seq_mag_comp: directed checks of seq_mag_comp for DIGIT=1 and DIGIT=4 instances.
module tb_seq_mag_comp;
  logic clk = 1'b0, rst = 1'b1, st1 = 1'b0, st4 = 1'b0, sgn = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy1, done1, yg1, yl1, ye1, busy4, done4, yg4, yl4, ye4;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  seq_mag_comp #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(st1), .a(a), .b(b),
`ifdef COMP_SIGNED_EN
    .sgn(sgn),
`endif
    .busy(busy1), .done(done1), .yg(yg1), .yl(yl1), .ye(ye1)
  );
  seq_mag_comp #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(st4), .a(a), .b(b),
`ifdef COMP_SIGNED_EN
    .sgn(sgn),
`endif
    .busy(busy4), .done(done4), .yg(yg4), .yl(yl4), .ye(ye4)
  );
  wire [4:0] o1 = {busy1, done1, yg1, yl1, ye1};
  wire [4:0] o4 = {busy4, done4, yg4, yl4, ye4};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] outs(input int sel);
    return sel != 0 ? o4 : o1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // one request; flags are {yg,yl,ye}
  task automatic run(input int sel, input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic ts, input logic [2:0] flags, input int lat_exp);
    int lat = 0;
    a = ta; b = tb; sgn = ts;
    if (sel != 0) st4 = 1'b1; else st1 = 1'b1;
    tick();
    st1 = 1'b0; st4 = 1'b0;
    check({tag, "_busy"}, 32'(outs(sel)[4]), 32'd1);
    while (!outs(sel)[3] && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, lat_exp);
    check({tag, "_flags"}, 32'(outs(sel)[2:0]), 32'(flags));
    check({tag, "_busy_at_done"}, 32'(outs(sel)[4]), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(outs(sel)[3]), 32'd0);
  endtask
  initial begin
    int lat;
    logic seen;
    tick(); tick();
    check("reset_d1", 32'(o1), 32'd0);
    check("reset_d4", 32'(o4), 32'd0);
    rst = 1'b0;
    tick();
    run(0, "a5_25", 8'hA5, 8'h25, 1'b0, 3'b100, 1);
    run(0, "10_11", 8'h10, 8'h11, 1'b0, 3'b010, 8);
    run(0, "3c_3c", 8'h3C, 8'h3C, 1'b0, 3'b001, 8);
    run(1, "d4_12_13", 8'h12, 8'h13, 1'b0, 3'b010, 2);
    run(1, "d4_92_13", 8'h92, 8'h13, 1'b0, 3'b100, 1);
`ifdef COMP_SIGNED_EN
    run(0, "s_ff_01", 8'hFF, 8'h01, 1'b1, 3'b010, 1);
    run(0, "u_ff_01", 8'hFF, 8'h01, 1'b0, 3'b100, 1);
    run(1, "d4_s_80_7f", 8'h80, 8'h7F, 1'b1, 3'b010, 1);
`endif
    run(1, "d4_f0_0f", 8'hF0, 8'h0F, 1'b0, 3'b100, 1);
    // mid-SCAN start/operand changes must be ignored
    a = 8'h10; b = 8'h11; st1 = 1'b1;
    tick();
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      st1 = i[0] ? 1'b0 : 1'b1;
      a = 8'hFF; b = 8'h00;
      tick();
      lat++;
    end
    st1 = 1'b0;
    while (!done1 && lat < 20) begin
      tick();
      lat++;
    end
    check("ign_lat", lat, 8);
    check("ign_flags", {yg1, yl1, ye1}, 3'b010);
    tick();
    // back-to-back: start during DONE goes straight to SCAN
    a = 8'hA5; b = 8'h25; st1 = 1'b1;
    tick();
    st1 = 1'b0;
    tick();
    check("b2b_first", {done1, yg1, yl1, ye1}, 4'b1100);
    a = 8'h10; b = 8'h11; st1 = 1'b1;
    tick();
    st1 = 1'b0;
    check("b2b_rescan", {busy1, done1, yg1, yl1, ye1}, 5'b10100);
    lat = 0;
    while (!done1 && lat < 20) begin
      tick();
      lat++;
    end
    check("b2b_lat", lat, 8);
    check("b2b_flags", {yg1, yl1, ye1}, 3'b010);
    tick();
    // reset on 3rd SCAN cycle with start high
    a = 8'h10; b = 8'h11; st1 = 1'b1;
    tick();
    st1 = 1'b0;
    tick(); tick();
    check("rst_pre_busy", busy1, 1'b1);
    rst = 1'b1; st1 = 1'b1;
    tick();
    check("rst_abort", 32'(o1), 32'd0);
    rst = 1'b0; st1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= done1 | busy1;
    end
    check("rst_no_done", seen, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_mag_comp.md
# seq_mag_comp

Parametrised, sequential, MSB-first magnitude comparator for two WIDTH-bit operands. It examines DIGIT bits per clock and terminates early on the first differing digit. Results are returned through a start/busy/done handshake as one-hot greater/less/equal flags. It is the multi-bit, multi-cycle successor to the team's single-bit comparator, intended for area-constrained datapaths where a full-width parallel compare is too costly.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 1.
- DIGIT, 1: bits compared per cycle; WIDTH % DIGIT must be 0. NDIG = WIDTH/DIGIT.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- sgn  in  1  two's-complement mode; sampled with start. Present only with COMP_SIGNED_EN.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse; result valid.
- yg  out  1  A > B.
- yl  out  1  A < B.
- ye  out  1  A == B.

## Operation
- The FSM has three states: IDLE, SCAN, DONE.
- IDLE, start=1: latch a, b (and sgn) into internal registers. Clear the digit counter. Go to SCAN.
- IDLE, start=0: stay in IDLE.
- SCAN: compare digit cnt of the latched operands, MSB digit first.
  - Digits differ: load yg/yl from that digit compare, clear ye, go to DONE.
  - Digits equal and cnt == NDIG-1: set ye=1, clear yg/yl, go to DONE.
  - Otherwise: increment cnt and stay in SCAN.
- DONE: done=1 for this cycle.
  - start=1: accept a new request exactly as from IDLE (back-to-back).
  - start=0: go to IDLE.
- start is ignored while in SCAN. Operands are not re-sampled.
- yg, yl and ye are always one-hot after the first completion. They hold their values until the next completion and do not clear when a new start is accepted.
- Reset values: busy=0, done=0, yg=0, yl=0, ye=0, state=IDLE, cnt=0. Before the first completion all three flags are 0.
- Reset mid-SCAN: abort on the next edge with the reset values above, even if start=1 in the same cycle. No done pulse is produced.
- The counter is $clog2(NDIG) bits wide, with a minimum of 1. When NDIG=1, SCAN always exits after one cycle.

## Timing
- Let E0 be the edge that samples start. busy=1 from E0 until the edge that enters DONE.
- If the first difference is in digit index k (0 = MSB digit), done=1 in the cycle following edge E(k+1). Latency is k+1 cycles, in the range 1..NDIG.
- For equal operands, latency is NDIG cycles.
- Result flags update on the same edge that raises done.
- Back-to-back throughput is one result every latency+1 cycles.
- There is no combinational path from inputs to outputs.

## Configuration
- COMP_SIGNED_EN defined:
  - The sgn port exists.
  - When the latched sgn=1, the MSB of both latched operands is inverted before scanning. This gives two's-complement ordering at no latency cost.
- COMP_SIGNED_EN undefined:
  - No sgn port.
  - Comparison is unsigned only.

## Structure
- Package comp_pkg holds:
  - typedef enum state_t {IDLE, SCAN, DONE};
  - localparam helpers NDIG and CNT_W;
  - a parameter legality check function (WIDTH % DIGIT == 0).
- Sub-module digit_comp is a combinational DIGIT-bit compare with outputs gt, lt and eq. The top level instantiates it once, fed by a mux that selects digit cnt.

## Test plan
- WIDTH=8, DIGIT=1: a=8'hA5, b=8'h25, start → done after 1 cycle with yg=1, yl=0, ye=0; busy high for exactly 1 cycle.
- WIDTH=8, DIGIT=1: a=8'h10, b=8'h11 → yl=1 after 8 cycles. Then a=b=8'h3C → ye=1 after 8 cycles; done pulses exactly once each time.
- WIDTH=8, DIGIT=4: a=8'h12, b=8'h13 → yl=1 after 2 cycles. Then a=8'h92, b=8'h13 → yg=1 after 1 cycle.
- COMP_SIGNED_EN: a=8'hFF, b=8'h01. With sgn=1 → yl=1 after 1 cycle; with sgn=0 → yg=1 after 1 cycle.
- Handshake: toggle start and change a, b mid-SCAN → ignored, and the result matches the originally latched operands. Start asserted in the DONE cycle → next SCAN begins with no IDLE cycle.
- Reset: assert rst on the 3rd SCAN cycle with start=1 → next cycle busy=0, done=0, yg=yl=ye=0, and no later done pulse.
